// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data memory responder: one outstanding request, a fixed
// run of wait states, then a held response until the initiator accepts it.
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DATA_W = 32;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The counter covers the acceptance cycle plus every wait state, so the
    // response appears WAIT_CYCLES+1 edges after the request handshake.
    localparam logic [8:0] CNT_LOAD = 9'(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [8:0]        cnt;
    logic [8:0]        cnt_n;
    logic              resp_enter;
    logic              req_hs;
    logic              in_range;

    logic              lat_we_p0;
    logic [31:0]       lat_addr_p0;
    logic [DATA_W-1:0] lat_wdata_p0;
    logic [AW-1:0]     mem_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [DATA_W-1:0] load_result(input logic          is_store,
                                                      input logic          ok,
                                                      input logic [DATA_W-1:0] word);
        return (!is_store && ok) ? word : '0;
    endfunction

    assign req_hs   = (state == IDLE) && req_valid;
    assign in_range = (lat_addr_p0 < 32'(DEPTH));
    assign mem_idx  = lat_addr_p0[AW-1:0];

    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        resp_enter = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_n = WAIT;
                    cnt_n   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == 9'd1) begin
                    state_n    = RESP;
                    cnt_n      = '0;
                    resp_enter = 1'b1;
                end else begin
                    cnt_n = cnt - 9'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // p0: request latched on the handshake edge
    always_ff @(posedge clk1) begin
        if (req_hs) begin
            lat_we_p0    <= req_we;
            lat_addr_p0  <= req_addr;
            lat_wdata_p0 <= req_wdata;
        end
    end

    // p1: response captured on RESP entry and held until accepted
    always_ff @(posedge clk1) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (resp_enter) begin
            rsp_err   <= !in_range;
            rsp_rdata <= load_result(lat_we_p0, in_range, mem[mem_idx]);
        end
    end

    always_ff @(posedge clk1) begin
        if (!reset && resp_enter && lat_we_p0 && in_range) begin
            mem[mem_idx] <= lat_wdata_p0;
        end
    end

endmodule
